// File: rtl/opcode_sequencer_pkg.sv
// Shared opcode, FSM state and error-code definitions for the opcode sequencer.
package opcode_sequencer_pkg;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_NOP  = 4'd0;
    localparam opcode_t OP_MUL  = 4'd1;
    localparam opcode_t OP_SQR  = 4'd2;
    localparam opcode_t OP_ADD  = 4'd3;
    localparam opcode_t OP_HALT = 4'd15;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_LATCH = 3'd2;
    localparam logic [2:0] ST_ISSUE = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_HALT  = 3'd5;
    localparam logic [2:0] ST_ERR   = 3'd6;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    function automatic logic is_datapath_op(input opcode_t op);
        return (op == OP_MUL) || (op == OP_SQR) || (op == OP_ADD);
    endfunction

endpackage

// File: rtl/opcode_sequencer_if.sv
// Command FIFO, datapath handshake and status signals of the opcode sequencer.
interface opcode_sequencer_if
    import opcode_sequencer_pkg::*;
#(
    parameter int DATA_W = 32
);
    logic              go;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_data;
    logic              mul_start;
    opcode_t           mul_op;
    logic [DATA_W-5:0] mul_operand;
    logic              mul_done;
    logic              busy;
    logic [1:0]        err;
    logic [7:0]        cmd_count;

    modport master (
        input  go, fifo_empty, fifo_data, mul_done,
        output fifo_rd_en, mul_start, mul_op, mul_operand, busy, err, cmd_count
    );

    modport slave (
        output go, fifo_empty, fifo_data, mul_done,
        input  fifo_rd_en, mul_start, mul_op, mul_operand, busy, err, cmd_count
    );
endinterface

// File: rtl/opcode_sequencer_seq_watchdog.sv
// Clearable saturating cycle counter; flags the cycle whose count reaches TMO_MAX.
module seq_watchdog #(
    parameter int TMO_W   = 8,
    parameter int TMO_MAX = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);

    localparam logic [TMO_W-1:0] LAST = TMO_W'(TMO_MAX - 1);

    logic [TMO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Looks at the value the counter is about to take, so the flag rises in the TMO_MAX-th counted cycle.
    assign expire_o = inc_i && (cnt_q >= LAST);

endmodule

// File: rtl/opcode_sequencer.sv
// Pops command words from a FIFO, retires NOP/HALT locally and hands MUL/SQR/ADD
// to an external datapath, guarding each datapath operation with a watchdog.
module opcode_sequencer
    import opcode_sequencer_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TMO_W   = 8,
    parameter int TMO_MAX = 200
) (
    input  logic               clk,
    input  logic               rst_n,
    opcode_sequencer_if.master bus
);

    logic [2:0]        state_q, state_d;
    logic [DATA_W-1:0] cmd_q, cmd_d;
    logic [1:0]        err_q, err_d;
    logic [7:0]        count_q, count_d;
    logic              go_q;
    logic              go_rise;
    logic              wd_expire;
    opcode_t           op;

    assign op      = cmd_q[DATA_W-1 -: 4];
    assign go_rise = bus.go && !go_q;

    seq_watchdog #(
        .TMO_W   (TMO_W),
        .TMO_MAX (TMO_MAX)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (state_q == ST_ISSUE),
        .inc_i    (state_q == ST_WAIT),
        .expire_o (wd_expire)
    );

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        err_d   = err_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE:  if (bus.go && !bus.fifo_empty) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_LATCH;
            ST_LATCH: begin
                cmd_d   = bus.fifo_data;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (op == OP_NOP) begin
                    count_d = count_q + 8'd1;
                    state_d = ST_IDLE;
                end else if (op == OP_HALT) begin
                    count_d = count_q + 8'd1;
                    state_d = ST_HALT;
                end else if (is_datapath_op(op)) begin
                    state_d = ST_WAIT;
                end else begin
                    err_d   = ERR_ILLEGAL;
                    state_d = ST_ERR;
                end
            end
            ST_WAIT: begin
                // A done pulse in the expiring cycle still retires the command.
                if (bus.mul_done) begin
                    count_d = count_q + 8'd1;
                    state_d = ST_IDLE;
                end else if (wd_expire) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_ERR;
                end
            end
            ST_HALT:  if (go_rise) state_d = ST_IDLE;
            ST_ERR: begin
                if (go_rise) begin
                    err_d   = ERR_NONE;
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            err_q   <= ERR_NONE;
            count_q <= '0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            err_q   <= err_d;
            count_q <= count_d;
            go_q    <= bus.go;
        end
    end

    // Opcode/operand come straight from the command register, so they hold through WAIT.
    assign bus.fifo_rd_en  = (state_q == ST_FETCH);
    assign bus.mul_start   = (state_q == ST_ISSUE) && is_datapath_op(op);
    assign bus.mul_op      = op;
    assign bus.mul_operand = cmd_q[DATA_W-5:0];
    assign bus.busy        = !((state_q == ST_IDLE) || (state_q == ST_HALT) || (state_q == ST_ERR));
    assign bus.err         = err_q;
    assign bus.cmd_count   = count_q;

endmodule

// File: tb/tb_opcode_sequencer.sv
// Directed and randomized bench for opcode_sequencer with a FIFO/datapath model and a
// transaction-level expectation of issued operations and retired-command count.
module tb_opcode_sequencer;

    localparam int DATA_W  = 32;
    localparam int TMO_W   = 8;
    localparam int TMO_MAX = 200;

    localparam logic [3:0] C_NOP  = 4'd0;
    localparam logic [3:0] C_MUL  = 4'd1;
    localparam logic [3:0] C_HALT = 4'd15;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    opcode_sequencer_if #(.DATA_W(DATA_W)) bus ();

    opcode_sequencer #(
        .DATA_W  (DATA_W),
        .TMO_W   (TMO_W),
        .TMO_MAX (TMO_MAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks = 0;
    int          failures = 0;
    int          exp_count = 0;
    int          rd_pulses = 0;
    int          start_pulses = 0;
    int          rd_viol = 0;
    int          hold_viol = 0;
    int          done_lat = 0;
    int          done_timer = 0;
    int          nticks;
    logic        prev_rd = 1'b0;
    logic        in_op = 1'b0;
    logic        obs_busy = 1'b0;
    logic [1:0]  obs_err = 2'd0;
    logic [31:0] cur_cmd = '0;
    logic [31:0] fifo_q[$];
    logic [31:0] obs_q[$];
    logic [31:0] exp_q[$];
    logic [3:0]  rop;
    logic [27:0] ropd;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One clock: observe at the falling edge, then update FIFO and datapath just after the rising edge.
    task automatic tick();
        logic popped;
        @(negedge clk);
        obs_busy = bus.busy;
        obs_err  = bus.err;
        if (bus.fifo_rd_en) begin
            rd_pulses++;
            if (bus.fifo_empty || prev_rd) rd_viol++;
        end
        prev_rd = bus.fifo_rd_en;
        if (in_op && bus.busy && !bus.mul_start && ({bus.mul_op, bus.mul_operand} !== cur_cmd)) hold_viol++;
        if (bus.mul_done || !bus.busy) in_op = 1'b0;
        if (bus.mul_start) begin
            start_pulses++;
            cur_cmd = {bus.mul_op, bus.mul_operand};
            obs_q.push_back(cur_cmd);
            in_op = 1'b1;
            done_timer = done_lat;
        end
        popped = bus.fifo_rd_en;
        @(posedge clk);
        #1;
        if (popped && (fifo_q.size() > 0)) bus.fifo_data = fifo_q.pop_front();
        bus.fifo_empty = (fifo_q.size() == 0);
        if (done_timer > 0) begin
            done_timer--;
            bus.mul_done = (done_timer == 0);
        end else if (done_lat != 0) begin
            bus.mul_done = 1'b0;
        end
    endtask

    task automatic push(input logic [3:0] op, input logic [27:0] opd);
        fifo_q.push_back({op, opd});
        bus.fifo_empty = 1'b0;
    endtask

    task automatic run_idle(input string tag, input int limit);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!((fifo_q.size() == 0) && !obs_busy && (done_timer == 0) && !bus.mul_done) && (n < limit));
        check({tag, "_settled"}, (n < limit), 1);
    endtask

    task automatic wait_start(input string tag);
        int s0 = start_pulses;
        int n = 0;
        while ((start_pulses == s0) && (n < 30)) begin
            tick();
            n++;
        end
        check({tag, "_start_seen"}, (n < 30), 1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rd_en"},   bus.fifo_rd_en,  0);
        check({tag, "_start"},   bus.mul_start,   0);
        check({tag, "_op"},      bus.mul_op,      0);
        check({tag, "_operand"}, bus.mul_operand, 0);
        check({tag, "_err"},     bus.err,         0);
        check({tag, "_count"},   bus.cmd_count,   0);
        check({tag, "_busy"},    bus.busy,        0);
    endtask

    task automatic clear_obs();
        rd_pulses = 0;
        start_pulses = 0;
        obs_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=stuck expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst_n = 1'b0;
        bus.go = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_data = '0;
        bus.mul_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("por");
        rst_n = 1'b1;
        tick();

        // Single MUL, done five cycles after start.
        clear_obs();
        done_lat = 5;
        push(C_MUL, 28'h123);
        bus.go = 1'b1;
        run_idle("mul1", 100);
        exp_count = (exp_count + 1) % 256;
        check("mul1_rd_pulses", rd_pulses, 1);
        check("mul1_starts", start_pulses, 1);
        check("mul1_cmd", obs_q[0], {C_MUL, 28'h0000123});
        check("mul1_count", bus.cmd_count, exp_count);
        check("mul1_busy", bus.busy, 0);

        // go high with an empty FIFO must never pop.
        clear_obs();
        repeat (20) tick();
        check("empty_rd_pulses", rd_pulses, 0);

        // NOP, NOP, HALT, MUL: stops in HALT until go re-rises.
        clear_obs();
        push(C_NOP, 28'h0); push(C_NOP, 28'h1); push(C_HALT, 28'h2); push(C_MUL, 28'h55);
        repeat (40) tick();
        exp_count = (exp_count + 3) % 256;
        check("halt_count", bus.cmd_count, exp_count);
        check("halt_no_start", start_pulses, 0);
        check("halt_fifo_left", fifo_q.size(), 1);
        check("halt_busy", bus.busy, 0);
        bus.go = 1'b0;
        tick();
        bus.go = 1'b1;
        run_idle("halt_rel", 100);
        exp_count = (exp_count + 1) % 256;
        check("halt_rel_count", bus.cmd_count, exp_count);
        check("halt_rel_starts", start_pulses, 1);
        check("halt_rel_cmd", obs_q[0], {C_MUL, 28'h55});

        // Illegal opcode 7 parks in ERR; a queued NOP waits for a go rising edge.
        clear_obs();
        ropd = 28'($urandom);
        push(4'd7, ropd);
        repeat (12) tick();
        push(C_NOP, 28'h0);
        repeat (12) tick();
        check("ill_err", bus.err, 1);
        check("ill_starts", start_pulses, 0);
        check("ill_count", bus.cmd_count, exp_count);
        check("ill_busy", bus.busy, 0);
        check("ill_stays", rd_pulses, 1);
        bus.go = 1'b0;
        tick();
        bus.go = 1'b1;
        run_idle("ill_rel", 100);
        exp_count = (exp_count + 1) % 256;
        check("ill_rel_err", bus.err, 0);
        check("ill_rel_count", bus.cmd_count, exp_count);

        // Datapath never answers: ERR one cycle after TMO_MAX WAIT cycles.
        clear_obs();
        done_lat = 0;
        push(C_MUL, 28'hBEEF);
        wait_start("tmo");
        nticks = 0;
        do begin
            tick();
            nticks++;
        end while ((obs_err == 2'd0) && (nticks < TMO_MAX + 20));
        check("tmo_wait_len", nticks, TMO_MAX + 1);
        check("tmo_err", bus.err, 2);
        check("tmo_count", bus.cmd_count, exp_count);
        bus.go = 1'b0;
        tick();
        bus.go = 1'b1;
        tick();
        tick();
        check("tmo_clear", bus.err, 0);

        // Done in the last WAIT cycle wins over the timeout.
        clear_obs();
        done_lat = TMO_MAX;
        push(C_MUL, 28'h77);
        run_idle("tmo_edge", TMO_MAX + 50);
        exp_count = (exp_count + 1) % 256;
        check("tmo_edge_err", bus.err, 0);
        check("tmo_edge_count", bus.cmd_count, exp_count);

        // Done one cycle late arrives in ERR and is ignored.
        done_lat = TMO_MAX + 1;
        push(C_MUL, 28'h78);
        run_idle("tmo_late", TMO_MAX + 50);
        check("tmo_late_err", bus.err, 2);
        check("tmo_late_count", bus.cmd_count, exp_count);
        bus.go = 1'b0;
        tick();
        bus.go = 1'b1;
        tick();

        // go dropping mid-operation lets the current command finish, then stops.
        clear_obs();
        done_lat = 3;
        push(C_MUL, 28'hA1); push(C_MUL, 28'hA2);
        wait_start("gofall");
        bus.go = 1'b0;
        repeat (20) tick();
        exp_count = (exp_count + 1) % 256;
        check("gofall_count", bus.cmd_count, exp_count);
        check("gofall_fifo_left", fifo_q.size(), 1);
        check("gofall_starts", start_pulses, 1);
        bus.go = 1'b1;
        run_idle("gofall_rel", 100);
        exp_count = (exp_count + 1) % 256;
        check("gofall_rel_count", bus.cmd_count, exp_count);

        // Random legal command streams against the transaction-level expectation.
        for (int b = 0; b < 3; b++) begin
            clear_obs();
            exp_q.delete();
            done_lat = $urandom_range(1, 8);
            for (int i = 0; i < 10; i++) begin
                rop  = 4'($urandom_range(0, 3));
                ropd = 28'($urandom);
                push(rop, ropd);
                if (rop != C_NOP) exp_q.push_back({rop, ropd});
                exp_count = (exp_count + 1) % 256;
            end
            run_idle($sformatf("rand%0d", b), 600);
            check($sformatf("rand%0d_nissued", b), obs_q.size(), exp_q.size());
            for (int i = 0; i < exp_q.size(); i++) begin
                check($sformatf("rand%0d_cmd%0d", b, i), obs_q[i], exp_q[i]);
            end
            check($sformatf("rand%0d_count", b), bus.cmd_count, exp_count);
            check($sformatf("rand%0d_err", b), bus.err, 0);
        end

        // Asynchronous reset in the middle of WAIT, then a stray done.
        done_lat = 0;
        push(C_MUL, 28'hABCDEF);
        wait_start("arst");
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("arst");
        in_op = 1'b0;
        bus.go = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_count = 0;
        bus.mul_done = 1'b1;
        tick();
        bus.mul_done = 1'b0;
        repeat (3) tick();
        check("stray_done_count", bus.cmd_count, exp_count);
        check("stray_done_busy", bus.busy, 0);
        check("stray_done_err", bus.err, 0);

        // 255 NOPs reach 255, one more wraps to 0.
        bus.go = 1'b1;
        for (int i = 0; i < 255; i++) push(C_NOP, 28'(i));
        run_idle("wrap255", 2000);
        exp_count = (exp_count + 255) % 256;
        check("wrap_255", bus.cmd_count, exp_count);
        push(C_NOP, 28'h0);
        run_idle("wrap0", 50);
        exp_count = (exp_count + 1) % 256;
        check("wrap_0", bus.cmd_count, exp_count);

        check("rd_en_rules", rd_viol, 0);
        check("op_hold", hold_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
